// File: rtl/button_pkg.sv
// button_pkg: shared types and elaboration-time helpers for button_events.
//   state_t      : IDLE / DELAY / REPEAT event FSM states
//   ms_to_cycles : converts a millisecond interval at freq_khz into clk cycles
//   cnt_width    : down-counter width able to hold the larger of two loads
package button_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  // kHz * ms = cycles
  function automatic int ms_to_cycles(input int freq_khz, input int ms);
    return freq_khz * ms;
  endfunction

  // Loads are N-1, so $clog2(N) bits suffice; never narrower than 1 bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    int w;
    m = (a > b) ? a : b;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_events.sv
// button_events: turns a clean, debounced button level into user events.
//   i_clk       : system clock
//   i_rst       : synchronous active-high reset
//   i_x         : debounced button level (XPOL = released level)
//   i_repEn     : enable auto-repeat pulses (sampled only at timer expiry)
//   o_press     : one-cycle pulse on press
//   o_release   : one-cycle pulse on release
//   o_repeat    : one-cycle pulse per auto-repeat tick
//   o_longPress : level, high while held past the initial delay
//   o_held      : registered pressed level
module button_events
  import button_pkg::*;
#(
  parameter int FREQ_KHZ = 50000,
  parameter int DELAY_MS = 500,
  parameter int RATE_MS  = 100,
  parameter bit XPOL     = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_x,
  input  logic i_repEn,
  output logic o_press,
  output logic o_release,
  output logic o_repeat,
  output logic o_longPress,
  output logic o_held
);

  localparam int DELAY_CYCLES = ms_to_cycles(FREQ_KHZ, DELAY_MS);
  localparam int RATE_CYCLES  = ms_to_cycles(FREQ_KHZ, RATE_MS);
  localparam int CW           = cnt_width(DELAY_CYCLES, RATE_CYCLES);
  localparam logic [CW-1:0] DELAY_LOAD = CW'(DELAY_CYCLES - 1);
  localparam logic [CW-1:0] RATE_LOAD  = CW'(RATE_CYCLES - 1);

  state_t          r_state, w_state_nx;
  logic [CW-1:0]   r_count, w_count_nx;
  logic            r_xPrev;
  logic            r_press, r_release, r_repeat, r_longPress, r_held;
  logic            w_rep_nx, w_long_nx;
  logic            w_p, w_press_edge, w_rel_edge;

  assign w_p          = (i_x == !XPOL);
  assign w_press_edge =  w_p && (r_xPrev == XPOL);
  assign w_rel_edge   = !w_p && (r_xPrev == !XPOL);

  // Release is checked first so it wins over a timer expiry on the same edge.
  always_comb begin
    w_state_nx = r_state;
    w_count_nx = r_count;
    w_rep_nx   = 1'b0;
    w_long_nx  = r_longPress;
    if (w_rel_edge) begin
      w_state_nx = IDLE;
      w_count_nx = '0;
      w_long_nx  = 1'b0;
    end else if (w_press_edge) begin
      w_state_nx = DELAY;
      w_count_nx = DELAY_LOAD;
      w_long_nx  = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_count_nx = '0;
          w_long_nx  = 1'b0;
        end
        DELAY: begin
          if (w_p) begin
            if (r_count != '0) begin
              w_count_nx = r_count - CW'(1);
            end else begin
              w_state_nx = REPEAT;
              w_count_nx = RATE_LOAD;
              w_long_nx  = 1'b1;
              w_rep_nx   = i_repEn;
            end
          end
        end
        REPEAT: begin
          if (w_p) begin
            if (r_count != '0) begin
              w_count_nx = r_count - CW'(1);
            end else begin
              w_count_nx = RATE_LOAD;
              w_rep_nx   = i_repEn;
            end
          end
        end
        default: begin
          w_state_nx = IDLE;
          w_count_nx = '0;
          w_long_nx  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_xPrev     <= XPOL;  // released, so a still-held button re-presses
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_repeat    <= 1'b0;
      r_longPress <= 1'b0;
      r_held      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_count     <= w_count_nx;
      r_xPrev     <= i_x;
      r_press     <= w_press_edge;
      r_release   <= w_rel_edge;
      r_repeat    <= w_rep_nx;
      r_longPress <= w_long_nx;
      r_held      <= w_p;
    end
  end

  assign o_press     = r_press;
  assign o_release   = r_release;
  assign o_repeat    = r_repeat;
  assign o_longPress = r_longPress;
  assign o_held      = r_held;

endmodule

// File: tb/tb_button_events.sv
// tb_button_events: directed scenarios for button_events with two instances
// (XPOL=1 and XPOL=0), DELAY_CYCLES=10, RATE_CYCLES=4. Expected outputs for
// each edge are derived from hold-time formulas and queued before the edge.
module tb_button_events;
  import button_pkg::*;

  typedef struct packed {
    logic prs;
    logic rel;
    logic rpt;
    logic lng;
    logic hld;
  } exp_t;

  localparam exp_t Z   = exp_t'(5'b00000);
  localparam exp_t REL = exp_t'(5'b01000);

  logic clk, rst, x, x0, en;
  logic p1, r1, t1, l1, h1;
  logic p0, r0, t0, l0, h0;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t q0[$];

  button_events #(.FREQ_KHZ(1), .DELAY_MS(10), .RATE_MS(4), .XPOL(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_x(x), .i_repEn(en),
    .o_press(p1), .o_release(r1), .o_repeat(t1), .o_longPress(l1), .o_held(h1)
  );

  button_events #(.FREQ_KHZ(1), .DELAY_MS(10), .RATE_MS(4), .XPOL(1'b0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_x(x0), .i_repEn(en),
    .o_press(p0), .o_release(r0), .o_repeat(t0), .o_longPress(l0), .o_held(h0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs after the i-th consecutive pressed edge (i=0 is the press edge).
  function automatic exp_t hold_exp(input int i, input bit rep_en);
    exp_t e;
    e.prs = (i == 0);
    e.rel = 1'b0;
    e.rpt = rep_en && (i >= 10) && (((i - 10) % 4) == 0);
    e.lng = (i >= 10);
    e.hld = 1'b1;
    return e;
  endfunction

  task automatic chk(input string tag, input exp_t ob, input exp_t ex);
    checks++;
    assert (ob === ex) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (prs rel rpt lng hld)", tag, ob, ex);
    end
  endtask

  task automatic cyc(input string tag, input logic vx, input logic vx0,
                     input logic ven, input logic vrst, input exp_t e, input exp_t e0);
    exp_t ob;
    q.push_back(e);
    q0.push_back(e0);
    x = vx; x0 = vx0; en = ven; rst = vrst;
    @(posedge clk);
    #1;
    ob = {p1, r1, t1, l1, h1};
    chk(tag, ob, q.pop_front());
    ob = {p0, r0, t0, l0, h0};
    chk({tag, "_xpol0"}, ob, q0.pop_front());
  endtask

  initial begin
    x = 1'b1; x0 = 1'b0; en = 1'b1; rst = 1'b1;
    @(posedge clk); #1;

    // Reset state, then idle
    for (int i = 0; i < 2; i++) cyc("reset", 1'b1, 1'b0, 1'b1, 1'b1, Z, Z);
    for (int i = 0; i < 2; i++) cyc("idle", 1'b1, 1'b0, 1'b1, 1'b0, Z, Z);

    // 1: short press
    for (int i = 0; i < 5; i++) cyc("s1_hold", 1'b0, 1'b0, 1'b1, 1'b0, hold_exp(i, 1'b1), Z);
    cyc("s1_rel", 1'b1, 1'b0, 1'b1, 1'b0, REL, Z);
    for (int i = 0; i < 2; i++) cyc("s1_idle", 1'b1, 1'b0, 1'b1, 1'b0, Z, Z);

    // 2: long hold with repeat enabled
    for (int i = 0; i < 25; i++) cyc("s2_hold", 1'b0, 1'b0, 1'b1, 1'b0, hold_exp(i, 1'b1), Z);
    cyc("s2_rel", 1'b1, 1'b0, 1'b1, 1'b0, REL, Z);
    for (int i = 0; i < 2; i++) cyc("s2_idle", 1'b1, 1'b0, 1'b1, 1'b0, Z, Z);

    // 3: same hold with repeat suppressed
    for (int i = 0; i < 25; i++) cyc("s3_hold", 1'b0, 1'b0, 1'b0, 1'b0, hold_exp(i, 1'b0), Z);
    cyc("s3_rel", 1'b1, 1'b0, 1'b0, 1'b0, REL, Z);
    for (int i = 0; i < 2; i++) cyc("s3_idle", 1'b1, 1'b0, 1'b1, 1'b0, Z, Z);

    // 4: release sampled on the delay-expiry edge wins over the expiry
    for (int i = 0; i < 10; i++) cyc("s4_hold", 1'b0, 1'b0, 1'b1, 1'b0, hold_exp(i, 1'b1), Z);
    cyc("s4_rel", 1'b1, 1'b0, 1'b1, 1'b0, REL, Z);
    checks++;
    assert (dut.r_state === IDLE) else begin
      errors++;
      $error("FAIL s4_state observed=%0d expected=%0d", dut.r_state, IDLE);
    end
    checks++;
    assert (dut.r_count === 4'd0) else begin
      errors++;
      $error("FAIL s4_count observed=%0d expected=0", dut.r_count);
    end
    for (int i = 0; i < 3; i++) cyc("s4_idle", 1'b1, 1'b0, 1'b1, 1'b0, Z, Z);

    // 5: reset mid-hold restarts with a fresh press
    for (int i = 0; i < 6; i++) cyc("s5_hold", 1'b0, 1'b0, 1'b1, 1'b0, hold_exp(i, 1'b1), Z);
    cyc("s5_rst", 1'b0, 1'b0, 1'b1, 1'b1, Z, Z);
    for (int i = 0; i < 12; i++) cyc("s5_rehold", 1'b0, 1'b0, 1'b1, 1'b0, hold_exp(i, 1'b1), Z);
    cyc("s5_rel", 1'b1, 1'b0, 1'b1, 1'b0, REL, Z);
    for (int i = 0; i < 2; i++) cyc("s5_idle", 1'b1, 1'b0, 1'b1, 1'b0, Z, Z);

    // 6: inverted polarity instance held high for 12 cycles
    for (int i = 0; i < 12; i++) cyc("s6_hold", 1'b1, 1'b1, 1'b1, 1'b0, Z, hold_exp(i, 1'b1));
    cyc("s6_rel", 1'b1, 1'b0, 1'b1, 1'b0, Z, REL);
    for (int i = 0; i < 2; i++) cyc("s6_idle", 1'b1, 1'b0, 1'b1, 1'b0, Z, Z);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
